// File: rtl/adaptive_filter_pkg.sv
// adaptive_filter_pkg: shared types and defaults for the adaptive FIR filter and its mode sequencer.
package adaptive_filter_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, RESET} ctrl_state_t;
  localparam logic MODE_DIFF = 1'b0;
  localparam logic MODE_INTEGR = 1'b1;
  localparam int CTRL_RST_CYCLES = 2;
  localparam int CTRL_BLANK_LEN = 10;
endpackage

// File: rtl/adaptive_filter_ctrl.sv
// adaptive_filter_ctrl: sequences filter mode changes, stalling the source during re-init and blanking the fill transient.
module adaptive_filter_ctrl
  import adaptive_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int RST_CYCLES = CTRL_RST_CYCLES,
  parameter int BLANK_LEN  = CTRL_BLANK_LEN
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  mode_req_valid,
  input  logic                  mode_req,
  output logic                  mode_req_ready,
  output logic                  mode,
  output logic                  busy,
  output logic                  switch_done,
  output logic                  f_srst,
  output logic                  f_ctrl,
  output logic [DATA_WIDTH-1:0] f_s_tdata,
  output logic                  f_s_tvalid,
  input  logic [DATA_WIDTH-1:0] f_m_tdata,
  input  logic                  f_m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int BW = BLANK_LEN > 0 ? $clog2(BLANK_LEN + 1) : 1;
  ctrl_state_t state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic pending_q, pending_d, mode_q, mode_d, sw_q, sw_d, done_q, done_d;
  logic req_acc, exit_reset;
  assign req_acc    = state_q == RUN && mode_req_valid;
  assign exit_reset = state_q == RESET && rst_cnt_q <= RW'(1);
  // sw_q distinguishes a requested switch from the post-reset exit, which must not pulse switch_done
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    sw_d      = sw_q;
    if (req_acc) begin
      state_d   = DRAIN;
      pending_d = mode_req;
      sw_d      = 1'b1;
    end
    if (state_q == DRAIN) begin
      state_d   = RESET;
      rst_cnt_d = RW'(RST_CYCLES);
      mode_d    = pending_q;
    end
    if (state_q == RESET) rst_cnt_d = rst_cnt_q - RW'(1);
    if (exit_reset) begin
      state_d = RUN;
      sw_d    = 1'b0;
    end
    done_d      = exit_reset & sw_q;
    blank_cnt_d = exit_reset ? BW'(BLANK_LEN)
                : (f_m_tvalid && blank_cnt_q != '0) ? blank_cnt_q - BW'(1) : blank_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= RESET;
      rst_cnt_q   <= RW'(RST_CYCLES);
      pending_q   <= MODE_DIFF;
      mode_q      <= MODE_DIFF;
      sw_q        <= 1'b0;
      done_q      <= 1'b0;
      blank_cnt_q <= BW'(BLANK_LEN);
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      sw_q        <= sw_d;
      done_q      <= done_d;
      blank_cnt_q <= blank_cnt_d;
    end
  end
  assign s_tready       = state_q == RUN;
  assign mode_req_ready = state_q == RUN;
  assign busy           = state_q != RUN;
  assign mode           = mode_q;
  assign f_ctrl         = mode_q;
  assign f_srst         = srst | (state_q == RESET);
  assign switch_done    = done_q;
  assign f_s_tvalid     = s_tvalid & s_tready;
  assign f_s_tdata      = s_tdata;
  assign m_tdata        = f_m_tdata;
  assign m_tvalid       = f_m_tvalid & (blank_cnt_q == '0);
endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// tb_adaptive_filter_ctrl: randomized scoreboard bench with a cycle-time reference model of the mode sequencer.
module tb_adaptive_filter_ctrl;
  localparam int R = 2;
  localparam int B = 10;
  logic clk = 1'b0;
  logic srst = 1'b1;
  logic [13:0] s_tdata = '0;
  logic s_tvalid = 1'b0, mode_req_valid = 1'b0, mode_req = 1'b0;
  logic s_tready, mode_req_ready, mode, busy, switch_done, f_srst, f_ctrl, f_s_tvalid, m_tvalid;
  logic [13:0] f_s_tdata, m_tdata;
  logic [13:0] f_m_tdata = '0;
  logic f_m_tvalid = 1'b0;
  int total = 0, bad = 0, cyc = 0;
  int exp_q[$];
  int done_q[$];

  adaptive_filter_ctrl #(.DATA_WIDTH(14), .RST_CYCLES(R), .BLANK_LEN(B)) dut (
    .clk(clk), .srst(srst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .mode_req_valid(mode_req_valid), .mode_req(mode_req), .mode_req_ready(mode_req_ready),
    .mode(mode), .busy(busy), .switch_done(switch_done), .f_srst(f_srst), .f_ctrl(f_ctrl),
    .f_s_tdata(f_s_tdata), .f_s_tvalid(f_s_tvalid), .f_m_tdata(f_m_tdata), .f_m_tvalid(f_m_tvalid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid));

  always #5 clk = ~clk;

  // filter stand-in: one-cycle latency, output tagged with the mode it was computed under
  always @(posedge clk) begin
    f_m_tvalid <= f_srst ? 1'b0 : f_s_tvalid;
    f_m_tdata  <= f_s_tdata + {13'b0, f_ctrl};
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
    end
  endtask

  // reference model: RUN resumes at a known cycle number after each accepted request or reset
  int run_from = 1 << 30, drain_at = -1, mode_at = 0, blank = B;
  logic old_m = 1'b0, new_m = 1'b0, out_v = 1'b0;
  logic [13:0] out_d = '0;
  always @(negedge clk) begin
    logic rdy, m;
    cyc++;
    rdy = cyc >= run_from;
    if (cyc == run_from) blank = B;
    if (out_v) begin
      if (blank == 0) exp_q.push_back(int'(out_d));
      else blank--;
    end
    out_v = 1'b0;
    if (srst) begin
      chk("f_srst_in_reset", f_srst, 1);
      run_from = cyc + 1 + R;
      drain_at = -1;
      while (done_q.size() > 0 && done_q[$] > cyc) void'(done_q.pop_back());
      old_m = 1'b0; new_m = 1'b0; mode_at = 0; blank = B;
    end else begin
      m = cyc >= mode_at ? new_m : old_m;
      chk("s_tready", s_tready, rdy);
      chk("mode_req_ready", mode_req_ready, rdy);
      chk("busy", busy, !rdy);
      chk("f_srst", f_srst, !rdy && cyc != drain_at);
      chk("f_ctrl", f_ctrl, m);
      chk("mode", mode, m);
      chk("f_s_tvalid", f_s_tvalid, s_tvalid && rdy);
      if (s_tvalid && rdy) begin
        chk("f_s_tdata", f_s_tdata, s_tdata);
        out_v = 1'b1;
        out_d = s_tdata + {13'b0, m};
      end
      if (rdy && mode_req_valid) begin
        drain_at = cyc + 1;
        run_from = cyc + 2 + R;
        done_q.push_back(cyc + 2 + R);
        old_m = m; new_m = mode_req; mode_at = cyc + 2;
      end
    end
  end

  // monitor: consumes expectations only when the DUT presents an output event
  always @(negedge clk) begin
    #1;
    if (switch_done === 1'b1) begin
      if (done_q.size() == 0) chk("switch_done_unexpected", 1, 0);
      else chk("switch_done_cycle", cyc, done_q.pop_front());
    end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
      chk("switch_done_missing", cyc, done_q.pop_front());
    end
    if (m_tvalid === 1'b1) begin
      if (exp_q.size() == 0) chk("m_tvalid_unexpected", 1, 0);
      else chk("m_tdata", m_tdata, exp_q.pop_front());
    end
  end

  task automatic drv(input logic rs, input logic sv, input logic [13:0] sd, input logic rv, input logic r);
    @(posedge clk);
    #1;
    srst = rs; s_tvalid = sv; s_tdata = sd; mode_req_valid = rv; mode_req = r;
  endtask

  initial begin
    logic rv, r;
    repeat (3) drv(1, 0, 0, 0, 0);
    for (int i = 0; i < R + 12; i++) drv(0, i >= R, 14'h0100, 0, 0);
    repeat (4) drv(0, 1, 14'h0123, 0, 0);
    for (int i = 0; i < 4; i++) drv(0, 1, 14'(i), 1, 1);
    for (int i = 0; i < 6; i++) drv(0, 1, 14'(i + 8), 1, 0);
    repeat (15) drv(0, 1, 14'h0050, 0, 0);
    drv(0, 1, 14'h0011, 1, 1);
    drv(0, 1, 14'h0012, 0, 0);
    drv(1, 0, 0, 0, 0);
    repeat (16) drv(0, 1, 14'h0033, 0, 0);
    drv(0, 1, 14'h0044, 1, 0);
    repeat (20) drv(0, 1, 14'h0055, 0, 0);
    repeat (3) begin
      drv(0, 1, 14'h0100, 0, 0);
      repeat (3) drv(0, 0, 14'h1FFF, 0, 0);
      drv(0, 1, 14'h3F00, 0, 0);
      repeat (3) drv(0, 0, 14'h2AAA, 0, 0);
    end
    rv = 1'b0; r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 400 == 0) begin
        repeat (1 + $urandom % 2) drv(1, 0, 0, 0, 0);
      end else begin
        rv = ($urandom % 12 == 0) || (rv && ($urandom % 3 != 0));
        if ($urandom % 4 == 0) r = 1'($urandom);
        drv(0, $urandom % 4 != 0, 14'($urandom), rv, r);
      end
    end
    repeat (20) drv(0, 0, 0, 0, 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
